// File: rtl/spi_pkg.sv
// Shared definitions for the MCU SPI return path: packet size, transmit
// FSM states and the bit-counter width helper.
package spi_pkg;

    // Two SPI bytes per transaction.
    localparam int DEFAULT_PACKET_BITS = 16;

    // Bit counter must hold 0..PACKET_BITS inclusive.
    localparam int BIT_CNT_W = $clog2(DEFAULT_PACKET_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } spi_tx_state_t;

    // Counter width for a non-default packet size.
    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Rise/fall pulse generator for an already synchronized signal.
module spi_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev;

    // Registered copy of the synced signal, compared against the live value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= RESET_VAL;
        end else begin
            prev <= sig;
        end
    end

    assign rise = sig & ~prev;
    assign fall = ~sig & prev;

endmodule

// File: rtl/spi_sync.sv
// Two-flop synchronizer for a raw asynchronous SPI pin.
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic synced
);

    logic meta;

    // Two back-to-back flops to settle metastability before use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= RESET_VAL;
            synced <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments so both flops sample the old
            // values on the same edge; blocking would collapse the chain.
            meta   <= pin;
            synced <= meta;
        end
    end

endmodule

// File: rtl/spi_tx_response.sv
// SPI peripheral transmitter (mode 0) returning a 16-bit response word to
// the MCU. A one-entry holding buffer is loaded from fabric; on cs falling
// the buffered word (or IDLE_WORD if none) is shifted out MSB first.
module spi_tx_response
    import spi_pkg::*;
#(
    parameter int                     PACKET_BITS = DEFAULT_PACKET_BITS,
    parameter logic [PACKET_BITS-1:0] IDLE_WORD   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sck,
    input  logic                   cs,
    output logic                   sdo,
    input  logic [PACKET_BITS-1:0] txData,
    input  logic                   txValid,
    output logic                   txReady,
    output logic                   busy,
    output logic                   done,
    output logic                   abort,
    output logic                   underrun
);

    localparam int               CNT_W    = cnt_width(PACKET_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACKET_BITS);

    // Synchronized pins and their edge pulses.
    logic sck_sync, cs_sync;
    logic sck_rise, sck_fall;
    logic cs_rise, cs_fall;

    // Transmit state.
    spi_tx_state_t          state, state_next;
    logic [PACKET_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [PACKET_BITS-1:0] hold_word;
    logic                   buf_full;

    // Decoded actions for this cycle.
    logic accept;
    logic load_shift;
    logic load_from_buf;
    logic cnt_clear;
    logic cnt_inc;
    logic do_shift;
    logic done_set;
    logic abort_set;
    logic underrun_set;

    // sck idles low in mode 0, cs idles high.
    spi_sync #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk    (clk),
        .reset  (reset),
        .pin    (sck),
        .synced (sck_sync)
    );

    spi_sync #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .reset  (reset),
        .pin    (cs),
        .synced (cs_sync)
    );

    spi_edge_detect #(.RESET_VAL(1'b0)) u_sck_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (sck_sync),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_edge_detect #(.RESET_VAL(1'b1)) u_cs_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (cs_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign txReady = ~buf_full;
    assign accept  = txValid & txReady;
    assign busy    = (state != IDLE);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, sdo and per-cycle action decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next    = state;
        sdo           = 1'b0;
        load_shift    = 1'b0;
        load_from_buf = 1'b0;
        cnt_clear     = 1'b0;
        cnt_inc       = 1'b0;
        do_shift      = 1'b0;
        done_set      = 1'b0;
        abort_set     = 1'b0;
        underrun_set  = 1'b0;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                    load_shift = 1'b1;
                    cnt_clear  = 1'b1;
                    // Uses the pre-cycle buffer flag: a word accepted in this
                    // same cycle waits for the next transaction.
                    if (buf_full) begin
                        load_from_buf = 1'b1;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
            end

            SHIFT: begin
                sdo = shift_reg[PACKET_BITS-1];
                // cs rising outranks any sck edge in the same cycle.
                if (cs_rise) begin
                    state_next = IDLE;
                    abort_set  = 1'b1;
                end else begin
                    if (sck_rise) begin
                        cnt_inc = 1'b1;
                        if ((bit_cnt + 1'b1) == LAST_CNT) begin
                            state_next = HOLD;
                        end
                    end
                    if (sck_fall && (bit_cnt < LAST_CNT)) begin
                        do_shift = 1'b1;
                    end
                end
            end

            HOLD: begin
                // Extra sck edges are ignored; sdo stays low until cs rises.
                if (cs_rise) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register: parallel load at cs fall, shift left on sck fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (load_shift) begin
            shift_reg <= load_from_buf ? hold_word : IDLE_WORD;
        end else if (do_shift) begin
            shift_reg <= {shift_reg[PACKET_BITS-2:0], 1'b0};
        end
    end

    // Count sampled bits (sck rises) within the current transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (cnt_clear) begin
            bit_cnt <= '0;
        end else if (cnt_inc) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // One-entry holding buffer between fabric and the shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the buffered word is reset too, so a reset mid-transfer
            // discards it rather than sending stale data later.
            hold_word <= '0;
            buf_full  <= 1'b0;
        end else begin
            if (accept) begin
                hold_word <= txData;
            end
            if (load_from_buf) begin
                buf_full <= 1'b0;
            end else if (accept) begin
                buf_full <= 1'b1;
            end
        end
    end

    // Registered one-cycle status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            abort    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            done     <= done_set;
            abort    <= abort_set;
            underrun <= underrun_set;
        end
    end

endmodule

// File: tb/tb_spi_tx_response.sv
// Self-checking bench for spi_tx_response: directed table of transactions,
// hand-written reset-mid-transfer sequence, and random transactions checked
// against a transaction-level model of the holding buffer and packet.
module tb_spi_tx_response;

    timeunit 1ns;
    timeprecision 1ps;

    logic        clk = 1'b0;
    logic        reset;
    logic        sck;
    logic        cs;
    logic        sdo;
    logic [15:0] txData;
    logic        txValid;
    logic        txReady;
    logic        busy;
    logic        done;
    logic        abort;
    logic        underrun;

    spi_tx_response dut (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .cs       (cs),
        .sdo      (sdo),
        .txData   (txData),
        .txValid  (txValid),
        .txReady  (txReady),
        .busy     (busy),
        .done     (done),
        .abort    (abort),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Pulse counters, sampled away from the active edge.
    int cnt_done  = 0;
    int cnt_abort = 0;
    int cnt_under = 0;

    always @(negedge clk) begin
        if (done)     cnt_done++;
        if (abort)    cnt_abort++;
        if (underrun) cnt_under++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word to the holding buffer, waiting a bounded time for room.
    task automatic load_word(input logic [15:0] d);
        int waited = 0;
        while (!txReady && waited < 20) begin
            tick();
            waited++;
        end
        check("load_wait_bounded", 32'(waited < 20), 32'd1);
        txData  = d;
        txValid = 1'b1;
        tick();
        txValid = 1'b0;
        check("txready_low_after_accept", txReady, 32'd0);
    endtask

    // One MCU transaction with nbits sck pulses (sck = clk/8). Optionally
    // offers a word on the exact cycle the cs fall is acted upon.
    task automatic xfer(input int nbits, input bit sim_valid, input logic [15:0] sim_data,
                        output logic [31:0] rx, output int d_done, output int d_abort,
                        output int d_under);
        int c0, a0, u0, lat;
        c0 = cnt_done;
        a0 = cnt_abort;
        u0 = cnt_under;
        rx = '0;
        cs = 1'b0;
        tick();
        tick();
        check("busy_before_csfall_acted", busy, 32'd0);
        if (sim_valid) begin
            txData  = sim_data;
            txValid = 1'b1;
        end
        tick();
        txValid = 1'b0;
        check("busy_3clk_after_cs_pin", busy, 32'd1);
        check("txready_after_csfall", txReady, 32'(!sim_valid));
        repeat (3) tick();
        for (int i = 0; i < nbits; i++) begin
            rx  = {rx[30:0], sdo};
            sck = 1'b1;
            repeat (4) tick();
            sck = 1'b0;
            repeat (4) tick();
        end
        repeat (4) tick();
        cs  = 1'b1;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (lat < 0 && (done || abort)) lat = k;
        end
        // Pulse is registered on the 3rd edge after the pin change and is
        // captured by fabric on the 4th.
        check("end_pulse_latency", 32'(lat), 32'd3);
        check("busy_after_transaction", busy, 32'd0);
        d_done  = cnt_done - c0;
        d_abort = cnt_abort - a0;
        d_under = cnt_under - u0;
    endtask

    typedef struct {
        bit          load;
        logic [15:0] data;
        int          nbits;
        bit          sim;
        logic [15:0] sim_data;
        logic [31:0] exp_rx;
        int          exp_done;
        int          exp_abort;
        int          exp_under;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] rx, exp_rx;
        int          dd, da, du;
        logic [15:0] model_buf;
        bit          model_full;
        logic [15:0] word, d;
        int          nb;
        bit          sim;

        vecs[0] = '{1'b1, 16'hA55A, 16, 1'b0, 16'h0000, 32'h0000A55A, 1, 0, 0};
        vecs[1] = '{1'b0, 16'h0000, 16, 1'b0, 16'h0000, 32'h00000000, 1, 0, 1};
        vecs[2] = '{1'b1, 16'hFFFF,  5, 1'b0, 16'h0000, 32'h0000001F, 0, 1, 0};
        vecs[3] = '{1'b0, 16'h0000, 16, 1'b0, 16'h0000, 32'h00000000, 1, 0, 1};
        vecs[4] = '{1'b0, 16'h0000, 16, 1'b1, 16'h1234, 32'h00000000, 1, 0, 1};
        vecs[5] = '{1'b0, 16'h0000, 16, 1'b0, 16'h0000, 32'h00001234, 1, 0, 0};
        vecs[6] = '{1'b1, 16'h8001, 20, 1'b0, 16'h0000, 32'h00080010, 1, 0, 0};
        vecs[7] = '{1'b0, 16'h0000,  0, 1'b0, 16'h0000, 32'h00000000, 0, 1, 1};

        reset   = 1'b1;
        cs      = 1'b1;
        sck     = 1'b0;
        txValid = 1'b0;
        txData  = '0;
        repeat (3) tick();
        check("reset_sdo", sdo, 32'd0);
        check("reset_txready", txReady, 32'd1);
        check("reset_busy", busy, 32'd0);
        check("reset_done", done, 32'd0);
        check("reset_abort", abort, 32'd0);
        check("reset_underrun", underrun, 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Directed table.
        foreach (vecs[v]) begin
            if (vecs[v].load) load_word(vecs[v].data);
            xfer(vecs[v].nbits, vecs[v].sim, vecs[v].sim_data, rx, dd, da, du);
            check($sformatf("vec%0d_rx", v), rx, vecs[v].exp_rx);
            check($sformatf("vec%0d_done", v), 32'(dd), 32'(vecs[v].exp_done));
            check($sformatf("vec%0d_abort", v), 32'(da), 32'(vecs[v].exp_abort));
            check($sformatf("vec%0d_underrun", v), 32'(du), 32'(vecs[v].exp_under));
        end

        // Reset while bit 7 of 0xC3C3 is on the wire.
        load_word(16'hC3C3);
        cs = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 7; i++) begin
            sck = 1'b1;
            repeat (4) tick();
            sck = 1'b0;
            repeat (4) tick();
        end
        check("sdo_bit7_before_reset", sdo, 32'd1);
        sck = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("midreset_sdo", sdo, 32'd0);
        check("midreset_busy", busy, 32'd0);
        check("midreset_txready", txReady, 32'd1);
        sck = 1'b0;
        cs  = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        xfer(16, 1'b0, 16'h0000, rx, dd, da, du);
        check("post_reset_rx", rx, 32'h0);
        check("post_reset_underrun", 32'(du), 32'd1);
        check("post_reset_done", 32'(dd), 32'd1);

        // Random transactions against a transaction-level model.
        model_full = 1'b0;
        model_buf  = '0;
        for (int t = 0; t < 30; t++) begin
            if (!model_full && ($urandom_range(0, 2) != 0)) begin
                d = 16'($urandom);
                load_word(d);
                model_full = 1'b1;
                model_buf  = d;
            end
            nb  = int'($urandom_range(0, 20));
            sim = !model_full && ($urandom_range(0, 3) == 0);
            d   = 16'($urandom);
            word = model_full ? model_buf : 16'h0000;
            exp_rx = '0;
            for (int i = 0; i < nb; i++) begin
                exp_rx = {exp_rx[30:0], (i < 16) ? word[15-i] : 1'b0};
            end
            xfer(nb, sim, d, rx, dd, da, du);
            check($sformatf("rand%0d_rx", t), rx, exp_rx);
            check($sformatf("rand%0d_done", t), 32'(dd), 32'(nb >= 16));
            check($sformatf("rand%0d_abort", t), 32'(da), 32'(nb < 16));
            check($sformatf("rand%0d_underrun", t), 32'(du), 32'(!model_full));
            model_full = sim;
            model_buf  = d;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
